uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Adds configurable data width, parity and stop-bit count, 3-sample majority voting, and start-bit validation.
- Reports framing and parity errors and delivers bytes over a valid/ready handshake with overrun detection.
- Sits between the board RX pin and protocol/command logic or an RX FIFO.

Parameters:
- CLK_FREQ, 48000000, system clock frequency in Hz.
- UART_BPS, 9600, baud rate. BPS_CNT = CLK_FREQ/UART_BPS (integer divide), must be >= 8. HALF = BPS_CNT/2.
- DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits expected: 1 or 2.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- uart_rxd  in  1  asynchronous serial input, idle high.
- rx_data  out  DATA_BITS  received word, valid while rx_valid=1.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid & rx_ready.
- rx_parity_err  out  1  parity mismatch for the word in rx_data; qualified by rx_valid.
- rx_frame_err  out  1  a stop bit sampled low for the word in rx_data; qualified by rx_valid.
- rx_overrun  out  1  one-cycle pulse: a frame completed while the holding register was still full.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low, sys_rst_n.
- Reset values: rx_data=0, rx_valid=0, both error flags 0, rx_overrun=0, rx_busy=0, FSM in IDLE, synchroniser flops=1 (idle line, so no false start after reset).
- Synchroniser: uart_rxd passes through 2 flops (s0, s1) plus a third flop s2 for edge detection. Start edge is s2=1 & s1=0.
- Baud counter: bit_cnt counts 0..BPS_CNT-1 and wraps; width is $clog2(BPS_CNT). It is cleared on entry to START.
- Sampling: s1 is captured at bit_cnt = HALF-1, HALF and HALF+1. The bit value is the 2-of-3 majority, resolved at bit_cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on start edge.
  - START: if the resolved bit = 1, it is a false start and the FSM returns to IDLE with no output and no flags. If resolved 0, go to DATA when bit_cnt = BPS_CNT-1.
  - DATA: shift resolved bits into a shift register, LSB first. After DATA_BITS bits, go to PARITY if PARITY != 0, else to STOP, at bit_cnt = BPS_CNT-1.
  - PARITY: odd mode requires XOR(data, parity bit) = 1; even mode requires it to be 0. The mismatch result is latched. Go to STOP at bit_cnt = BPS_CNT-1.
  - STOP: any resolved stop bit = 0 sets the frame-error latch. After the last stop bit resolves (at HALF+1), go to IDLE immediately, without waiting out the rest of the bit, so a following start edge is caught.
- Completion: the cycle after the final stop-bit resolution, the frame is offered to the output stage.
  - If rx_valid=0, or rx_valid & rx_ready in that same cycle: load rx_data and both error flags, and set rx_valid=1.
  - Otherwise: discard the new frame, keep the old word, and pulse rx_overrun for 1 cycle.
- Handshake:
  - rx_valid clears on the cycle after rx_valid & rx_ready, unless a new load occurs in that same cycle, in which case it stays 1 with the new data.
  - rx_data and the error flags are stable while rx_valid=1 and not accepted.
  - When rx_valid=0, rx_data and the error flags hold their last value. They are not cleared.
- Latency: rx_valid rises 1 cycle after the HALF+1 point of the last stop bit.
- Error frames are still delivered, with their flags set. The consumer decides whether to drop them.
- An asynchronous reset mid-frame aborts the frame. The block returns to reset values and receives the next start edge normally.

Test Plan:
- Test configuration: CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10), unless noted otherwise.
- 8N1, send 0xA5 with rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, both error flags 0, rx_overrun never asserted.
- DATA_BITS=7, PARITY=2 (even): send 0x55 with parity bit 1 -> rx_data=0x55, rx_parity_err=1. Resend with parity bit 0 -> rx_parity_err=0.
- 8N1, send 0x3C with the stop bit driven low -> rx_data=0x3C, rx_frame_err=1. A following valid 0x12 frame -> rx_data=0x12, rx_frame_err=0.
- Noise rejection:
  - A 3-cycle low glitch on an idle line -> false start, rx_busy returns to 0, no rx_valid.
  - A 1-cycle inverted glitch at HALF within a data bit -> the majority vote recovers the correct byte.
- Back-to-back frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11 and rx_overrun pulses once. After asserting rx_ready, a subsequent 0x33 is received correctly.
- Reset and stop-bit handling:
  - Assert sys_rst_n=0 during data bit 4, then release -> all outputs return to 0 and the next full 0x7E frame is received correctly.
  - With STOP_BITS=2, a low second stop bit -> rx_frame_err=1.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver: configurable data width (5..9, LSB first),
//   parity (none/odd/even) and 1 or 2 stop bits. The line passes through a
//   2-flop synchroniser. Each bit is taken as a 2-of-3 majority vote around
//   mid-bit, and the start bit is validated by that vote. Received words are
//   offered over a valid/ready handshake, with overrun detection.
//
// Ports
//   sys_clk        in   system clock, rising edge
//   sys_rst_n      in   asynchronous active-low reset
//   uart_rxd       in   asynchronous serial input, idle high
//   rx_data        out  received word, valid while rx_valid=1
//   rx_valid       out  word available; held until accepted
//   rx_ready       in   consumer accepts when rx_valid & rx_ready
//   rx_parity_err  out  parity mismatch for the word in rx_data
//   rx_frame_err   out  a stop bit was sampled low for the word in rx_data
//   rx_overrun     out  1-cycle pulse: frame finished while holding reg full
//   rx_busy        out  receiver is inside a frame
// ----------------------------------------------------------------------------
module uart_rx_cfg #(
   parameter int CLK_FREQ  = 48000000,
   parameter int UART_BPS  = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int HALF    = BPS_CNT / 2;
   localparam int CW      = $clog2(BPS_CNT);
   localparam int DCW     = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t               r_state;
   logic                 r_s0, r_s1, r_s2;
   logic [CW-1:0]        r_cnt;
   logic [1:0]           r_smp;
   logic [DATA_BITS-1:0] r_shift;
   logic [DCW-1:0]       r_dcnt;
   logic                 r_scnt;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_done;
   logic                 r_busy;

   logic w_start_edge;
   logic w_at_s0, w_at_s1, w_resolve, w_bit_end;
   logic w_bit;
   logic w_par_x;

   assign w_start_edge = r_s2 & ~r_s1;
   assign w_at_s0      = (r_cnt == CW'(HALF - 1));
   assign w_at_s1      = (r_cnt == CW'(HALF));
   assign w_resolve    = (r_cnt == CW'(HALF + 1));
   assign w_bit_end    = (r_cnt == CW'(BPS_CNT - 1));
   // third vote is the live synchroniser output at HALF+1
   assign w_bit        = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_s1) | (r_smp[1] & r_s1);
   assign w_par_x      = (^r_shift) ^ w_bit;

   assign rx_busy = r_busy;

   // Receive FSM, synchroniser, baud counter and bit sampling
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
         r_s0    <= 1'b1;
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_cnt   <= '0;
         r_smp   <= '0;
         r_shift <= '0;
         r_dcnt  <= '0;
         r_scnt  <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_s0   <= uart_rxd;
         r_s1   <= r_s0;
         r_s2   <= r_s1;
         r_done <= 1'b0;

         if (r_state != ST_IDLE)
            r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
         if (w_at_s0) r_smp[0] <= r_s1;
         if (w_at_s1) r_smp[1] <= r_s1;

         case (r_state)
            ST_IDLE: begin
               if (w_start_edge) begin
                  r_state <= ST_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_perr  <= 1'b0;
                  r_ferr  <= 1'b0;
                  r_dcnt  <= '0;
                  r_scnt  <= 1'b0;
               end
            end
            ST_START: begin
               if (w_resolve && w_bit) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_bit_end) begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_resolve) begin
                  r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                  r_dcnt  <= r_dcnt + 1'b1;
               end
               if (w_bit_end && (r_dcnt == DCW'(DATA_BITS))) begin
                  r_dcnt  <= '0;
                  r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (w_resolve)
                  r_perr <= (PARITY == 1) ? ~w_par_x : w_par_x;
               if (w_bit_end)
                  r_state <= ST_STOP;
            end
            ST_STOP: begin
               // leave at mid-bit of the last stop bit so a start edge
               // directly behind it is not missed
               if (w_resolve) begin
                  if (!w_bit) r_ferr <= 1'b1;
                  if (r_scnt == 1'(STOP_BITS - 1)) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_scnt <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Output holding register with valid/ready handshake
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (r_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data       <= r_shift;
               rx_parity_err <= r_perr;
               rx_frame_err  <= r_ferr;
               rx_valid      <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_cfg
//   Directed bench for uart_rx_cfg at BPS_CNT=10. Three receivers share the
//   clock and reset: A = 8N1, B = 7 data bits even parity, C = 8 data bits
//   two stop bits. One serial driver is steered to a receiver by 'sel'.
// ----------------------------------------------------------------------------
module tb_uart_rx_cfg;

   localparam int BIT = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_line;
   int         sel;

   logic       rxd_a, rxd_b, rxd_c;
   logic       rdy_a, rdy_b, rdy_c;
   logic [7:0] data_a, data_c;
   logic [6:0] data_b;
   logic       val_a, val_b, val_c;
   logic       perr_a, perr_b, perr_c;
   logic       ferr_a, ferr_b, ferr_c;
   logic       ovr_a, ovr_b, ovr_c;
   logic       busy_a, busy_b, busy_c;

   int n_checks = 0;
   int n_errors = 0;

   // accepted-word monitors
   int         acc_a = 0, ovrcnt_a = 0, acc_b = 0, acc_c = 0;
   logic [7:0] last_a = '0, last_c = '0;
   logic [6:0] last_b = '0;
   logic       lperr_a = 1'b0, lferr_a = 1'b0, lperr_b = 1'b0, lferr_c = 1'b0;

   assign rxd_a = (sel == 0) ? tx_line : 1'b1;
   assign rxd_b = (sel == 1) ? tx_line : 1'b1;
   assign rxd_c = (sel == 2) ? tx_line : 1'b1;

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1)) u_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_a), .rx_data(data_a),
      .rx_valid(val_a), .rx_ready(rdy_a), .rx_parity_err(perr_a),
      .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .rx_busy(busy_a));

   uart_rx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1)) u_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_b), .rx_data(data_b),
      .rx_valid(val_b), .rx_ready(rdy_b), .rx_parity_err(perr_b),
      .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .rx_busy(busy_b));

   uart_rx_cfg #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2)) u_c (
      .sys_clk(clk), .sys_rst_n(rst_n), .uart_rxd(rxd_c), .rx_data(data_c),
      .rx_valid(val_c), .rx_ready(rdy_c), .rx_parity_err(perr_c),
      .rx_frame_err(ferr_c), .rx_overrun(ovr_c), .rx_busy(busy_c));

   always @(negedge clk) begin
      if (val_a && rdy_a) begin
         acc_a++; last_a = data_a; lperr_a = perr_a; lferr_a = ferr_a;
      end
      if (ovr_a) ovrcnt_a++;
      if (val_b && rdy_b) begin
         acc_b++; last_b = data_b; lperr_b = perr_b;
      end
      if (val_c && rdy_c) begin
         acc_c++; last_c = data_c; lferr_c = ferr_c;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drive_bit(input logic v, input logic glitch);
      tx_line = v;
      if (glitch) begin
         repeat (5) @(posedge clk); #1;
         tx_line = ~v;
         @(posedge clk); #1;
         tx_line = v;
         repeat (BIT - 6) @(posedge clk); #1;
      end else begin
         repeat (BIT) @(posedge clk); #1;
      end
   endtask

   // par: -1 no parity bit, otherwise value of the parity bit sent
   task automatic send_frame(input logic [8:0] d, input int nbits, input int par,
                             input logic st1, input logic st2, input int nstop,
                             input int glitch_bit);
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(d[i], i == glitch_bit);
      if (par >= 0) drive_bit(par[0], 1'b0);
      drive_bit(st1, 1'b0);
      if (nstop == 2) drive_bit(st2, 1'b0);
      tx_line = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; tx_line = 1'b1; sel = 0;
      rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
      repeat (3) @(posedge clk); #2;
      check_eq("rst_data", {24'd0, data_a}, 32'h0);
      check_eq("rst_valid", {31'd0, val_a}, 32'd0);
      check_eq("rst_flags", {29'd0, perr_a, ferr_a, ovr_a}, 32'd0);
      check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
      rst_n = 1'b1;
      settle(5);

      // 8N1 basic frame
      send_frame(9'h0A5, 8, -1, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("a5_count", acc_a, 1);
      check_eq("a5_data", {24'd0, last_a}, 32'hA5);
      check_eq("a5_flags", {30'd0, lperr_a, lferr_a}, 32'd0);
      check_eq("a5_no_ovr", ovrcnt_a, 0);
      check_eq("a5_valid_clr", {31'd0, val_a}, 32'd0);

      // stop bit low -> framing error, then clean frame clears it
      send_frame(9'h03C, 8, -1, 1'b0, 1'b1, 1, -1);
      settle(4);
      check_eq("3c_data", {24'd0, last_a}, 32'h3C);
      check_eq("3c_ferr", {31'd0, lferr_a}, 32'd1);
      send_frame(9'h012, 8, -1, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("12_data", {24'd0, last_a}, 32'h12);
      check_eq("12_ferr", {31'd0, lferr_a}, 32'd0);

      // 3-cycle low glitch on idle line -> false start
      tx_line = 1'b0;
      repeat (3) @(posedge clk); #1;
      tx_line = 1'b1;
      @(negedge clk);
      check_eq("glitch_busy_hi", {31'd0, busy_a}, 32'd1);
      settle(15);
      check_eq("glitch_busy_lo", {31'd0, busy_a}, 32'd0);
      check_eq("glitch_no_word", acc_a, 3);

      // 1-cycle inverted glitch at mid-bit of data bit 3
      send_frame(9'h096, 8, -1, 1'b1, 1'b1, 1, 3);
      settle(4);
      check_eq("vote_count", acc_a, 4);
      check_eq("vote_data", {24'd0, last_a}, 32'h96);

      // overrun: two frames while not ready
      rdy_a = 1'b0;
      send_frame(9'h011, 8, -1, 1'b1, 1'b1, 1, -1);
      send_frame(9'h022, 8, -1, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("ovr_valid", {31'd0, val_a}, 32'd1);
      check_eq("ovr_hold", {24'd0, data_a}, 32'h11);
      check_eq("ovr_pulse", ovrcnt_a, 1);
      rdy_a = 1'b1;
      settle(3);
      check_eq("ovr_accept", {24'd0, last_a}, 32'h11);
      check_eq("ovr_vclr", {31'd0, val_a}, 32'd0);
      send_frame(9'h033, 8, -1, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("33_data", {24'd0, last_a}, 32'h33);
      check_eq("33_count", acc_a, 6);
      check_eq("33_ovr", ovrcnt_a, 1);

      // reset during data bit 4
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
      tx_line = 1'b0;
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check_eq("mid_rst_data", {24'd0, data_a}, 32'h0);
      check_eq("mid_rst_busy", {31'd0, busy_a}, 32'd0);
      tx_line = 1'b1;
      settle(3);
      rst_n = 1'b1;
      settle(5);
      check_eq("post_rst_valid", {31'd0, val_a}, 32'd0);
      send_frame(9'h07E, 8, -1, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("7e_data", {24'd0, last_a}, 32'h7E);
      check_eq("7e_count", acc_a, 7);

      // 7 data bits, even parity: 0x55 has four ones
      sel = 1;
      settle(3);
      send_frame(9'h055, 7, 1, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("par_bad_data", {25'd0, last_b}, 32'h55);
      check_eq("par_bad_err", {31'd0, lperr_b}, 32'd1);
      send_frame(9'h055, 7, 0, 1'b1, 1'b1, 1, -1);
      settle(4);
      check_eq("par_ok_err", {31'd0, lperr_b}, 32'd0);
      check_eq("par_count", acc_b, 2);

      // two stop bits
      sel = 2;
      settle(3);
      send_frame(9'h05A, 8, -1, 1'b1, 1'b0, 2, -1);
      settle(4);
      check_eq("stop2_data", {24'd0, last_c}, 32'h5A);
      check_eq("stop2_ferr", {31'd0, lferr_c}, 32'd1);
      send_frame(9'h0C3, 8, -1, 1'b1, 1'b1, 2, -1);
      settle(4);
      check_eq("stop2_ok_data", {24'd0, last_c}, 32'hC3);
      check_eq("stop2_ok_ferr", {31'd0, lferr_c}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
